// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: forwards CPU data-memory accesses to RAM and decodes the top 256 words as
// MMIO (LED, TX FIFO, STATUS, CYCLE). Define `MMIO_CYCLE_COUNTER_EN to build the cycle counter.
module dmem_mmio_bridge #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_wen,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_TX     = 8'h01;
    localparam logic [7:0] OFF_STATUS = 8'h02;
    localparam logic [7:0] OFF_CYCLE  = 8'h03;

    logic       hit;
    logic       mmio_wr;
    logic [7:0] offset;

    assign hit     = (cpu_addr[11:8] == MMIO_BASE[11:8]);
    assign offset  = cpu_addr[7:0];
    assign mmio_wr = cpu_wren & hit;

    assign ram_addr  = cpu_addr[11:0];
    assign ram_wdata = cpu_wdata;
    assign ram_wen   = cpu_wren & ~hit;

    // Address bits above the 12-bit data space are deliberately not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[31:12];

    // ---------------- LED register ----------------
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset)
            led <= '0;
        else if (mmio_wr && offset == OFF_LED)
            led <= cpu_wdata[15:0];
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, pop, push, push_ok, ovf;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign tx_valid = ~empty;
    assign pop      = tx_valid & tx_ready;
    assign push     = mmio_wr && (offset == OFF_TX);
    assign push_ok  = push & (~full | pop);
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !push_ok)
                ovf <= 1'b1;
            else if (mmio_wr && offset == OFF_STATUS)
                ovf <= 1'b0;
        end
    end

    // NOTE: storage array has no reset; empty-gating of tx_data hides stale contents.
    always_ff @(posedge clock) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= cpu_wdata[7:0];
    end

    // ---------------- Cycle counter ----------------
    logic [31:0] cycle_val;
`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cycle_val <= '0;
        else if (mmio_wr && offset == OFF_CYCLE)
            cycle_val <= cpu_wdata;
        else
            cycle_val <= cycle_val + 32'd1;
    end
`else
    assign cycle_val = '0;
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^cpu_wdata[31:16];
`endif

    // ---------------- Read path ----------------
    logic [31:0] mmio_rdata;
    logic [31:0] mmio_q;
    logic        sel_q;

    always_comb begin
        // NOTE: default assignment first so no path leaves mmio_rdata unassigned (no latch).
        mmio_rdata = '0;
        case (offset)
            OFF_LED:    mmio_rdata = {16'h0, led};
            OFF_STATUS: mmio_rdata = {28'h0, ovf, full, empty, tx_ready};
            OFF_CYCLE:  mmio_rdata = cycle_val;
            default:    mmio_rdata = '0;
        endcase
    end

    // Reset selects the MMIO path with zero data so loads read 0 until the first edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q  <= 1'b1;
            mmio_q <= '0;
        end else begin
            sel_q  <= hit;
            mmio_q <= mmio_rdata;
        end
    end

    assign cpu_rdata = sel_q ? mmio_q : ram_rdata;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: directed vector table, FIFO/counter/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_dmem_mmio_bridge;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_wren;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_mmio_bridge #(.FIFO_DEPTH(DEPTH), .MMIO_BASE(12'hF00)) dut (
        .clock(clock), .reset(reset),
        .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .led(led), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clock = ~clock;

    // Registered RAM with one-cycle read latency (read returns the old word on a same-cycle write).
    logic [31:0] ram_mem [4096];
    always @(posedge clock) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
    end

    // ---------------- Reference model ----------------
    logic [15:0] m_led;
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic [7:0]  m_q[$];
    logic [31:0] m_ram [4096];

    task automatic model_reset();
        m_led = '0;
        m_ovf = 1'b0;
        m_cnt = '0;
        m_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic rdy);
        if (addr[11:8] != 4'hF) return m_ram[addr[11:0]];
        if (addr[7:0] == 8'h00) return {16'h0, m_led};
        if (addr[7:0] == 8'h02)
            return {28'h0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, rdy};
`ifdef MMIO_CYCLE_COUNTER_EN
        if (addr[7:0] == 8'h03) return m_cnt;
`endif
        return 32'h0;
    endfunction

    task automatic model_update(input logic wren, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rdy);
        bit is_mmio, do_pop, do_push, accept;
        is_mmio = (addr[11:8] == 4'hF);
        do_pop  = (m_q.size() > 0) && rdy;
        do_push = wren && is_mmio && addr[7:0] == 8'h01;
        accept  = do_push && ((m_q.size() < DEPTH) || do_pop);
        if (do_pop) void'(m_q.pop_front());
        if (accept) m_q.push_back(wdata[7:0]);
        if (do_push && !accept) m_ovf = 1'b1;
        if (wren && is_mmio && addr[7:0] == 8'h02) m_ovf = 1'b0;
        if (wren && is_mmio && addr[7:0] == 8'h00) m_led = wdata[15:0];
        if (wren && is_mmio && addr[7:0] == 8'h03) m_cnt = wdata;
        else m_cnt = m_cnt + 32'd1;
        if (wren && !is_mmio) m_ram[addr[11:0]] = wdata;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, check combinational RAM controls, clock, check registered outputs.
    task automatic step(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rdy, output logic [31:0] got_rdata, output logic got_wen);
        logic [31:0] exp_rd;
        cpu_wren  = wren;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tx_ready  = rdy;
        #1;
        got_wen = ram_wen;
        check("ram_wen", {31'h0, ram_wen}, {31'h0, wren && addr[11:8] != 4'hF});
        check("ram_addr", {20'h0, ram_addr}, {20'h0, addr[11:0]});
        exp_rd = model_read(addr, rdy);
        model_update(wren, addr, wdata, rdy);
        @(posedge clock);
        #1;
        got_rdata = cpu_rdata;
        check("cpu_rdata", cpu_rdata, exp_rd);
        check("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
        check("tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
        check("led", {16'h0, led}, {16'h0, m_led});
    endtask

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        exp_wen;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        wen;
        logic [31:0] exp_cyc;

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 16'h0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 16'h0000});
        vecs.push_back('{1'b1, 32'h0000_0F00, 32'h0001_A5A5, 1'b0, 1'b0, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h0000_0F00, 32'h0,         1'b0, 1'b0, 32'h0000_A5A5, 16'hA5A5});
        vecs.push_back('{1'b1, 32'h0000_0F04, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h0000_0F04, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b1, 32'h0000_0EFF, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h5555_5EFF, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 16'hA5A5});
        vecs.push_back('{1'b1, 32'h0000_0FFF, 32'h1111_1111, 1'b0, 1'b0, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h0000_0FFF, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h0000_0F02, 32'h0,         1'b0, 1'b0, 32'h0000_0002, 16'hA5A5});
        vecs.push_back('{1'b0, 32'h0000_0F02, 32'h0,         1'b1, 1'b0, 32'h0000_0003, 16'hA5A5});
        vecs.push_back('{1'b0, 32'hABCD_EF00, 32'h0,         1'b0, 1'b0, 32'h0000_A5A5, 16'hA5A5});

        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            m_ram[i]   = '0;
        end
        reset = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0; tx_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #3;
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset tx_data", {24'h0, tx_data}, 32'h0);
        check("reset led", {16'h0, led}, 32'h0);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wren, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, rd, wen);
            check($sformatf("vec%0d ram_wen", i), {31'h0, wen}, {31'h0, vecs[i].exp_wen});
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
        end

        // Overflow: 9 pushes into a stalled FIFO, then drain in order.
        for (int i = 1; i <= 9; i++) step(1'b1, 32'hF01, i, 1'b0, rd, wen);
        step(1'b0, 32'hF02, 32'h0, 1'b0, rd, wen);
        check("ovf status", rd, 32'h0000_000C);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d valid", i), {31'h0, tx_valid}, 32'h1);
            check($sformatf("drain%0d data", i), {24'h0, tx_data}, i);
            step(1'b0, 32'h000, 32'h0, 1'b1, rd, wen);
        end
        check("drained valid", {31'h0, tx_valid}, 32'h0);
        step(1'b1, 32'hF02, 32'h0, 1'b0, rd, wen);
        step(1'b0, 32'hF02, 32'h0, 1'b0, rd, wen);
        check("ovf cleared", rd, 32'h0000_0002);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 8; i++) step(1'b1, 32'hF01, 32'h10 + i, 1'b0, rd, wen);
        step(1'b1, 32'hF01, 32'h18, 1'b1, rd, wen);
        step(1'b0, 32'hF02, 32'h0, 1'b0, rd, wen);
        check("full push+pop status", rd, 32'h0000_0004);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp drain%0d data", i), {24'h0, tx_data}, 32'h11 + i);
            step(1'b0, 32'h000, 32'h0, 1'b1, rd, wen);
        end
        check("pp drained valid", {31'h0, tx_valid}, 32'h0);

        // Cycle counter load and wrap.
        step(1'b1, 32'hF03, 32'hFFFF_FFFE, 1'b0, rd, wen);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'hF03, 32'h0, 1'b0, rd, wen);
`ifdef MMIO_CYCLE_COUNTER_EN
            exp_cyc = 32'hFFFF_FFFE + i;
`else
            exp_cyc = 32'h0;
`endif
            check($sformatf("cycle read%0d", i), rd, exp_cyc);
        end

        // Asynchronous reset with bytes queued and a nonzero load pending.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hF01, 32'hA0 + i, 1'b0, rd, wen);
        step(1'b1, 32'hF00, 32'h0000_00FF, 1'b0, rd, wen);
        step(1'b0, 32'hF00, 32'h0, 1'b0, rd, wen);
        check("pre-reset led read", rd, 32'h0000_00FF);
        #2 reset = 1'b0;
        #1;
        check("async tx_valid", {31'h0, tx_valid}, 32'h0);
        check("async tx_data", {24'h0, tx_data}, 32'h0);
        check("async led", {16'h0, led}, 32'h0);
        check("async cpu_rdata", cpu_rdata, 32'h0);
        #2 reset = 1'b1;
        model_reset();
        step(1'b0, 32'hF02, 32'h0, 1'b0, rd, wen);
        check("post-reset status", rd, 32'h0000_0002);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 9) < 5)
                a[11:0] = 12'hF00 | 12'($urandom_range(0, 5));
            else
                a[11:0] = 12'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0), rd, wen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
